// File: rtl/psram_line_fetch.sv
// rtl/psram_line_fetch.sv - fetches one display line from PSRAM in bursts and unpacks XRGB words into the line buffer
module psram_line_fetch #(
    parameter int H_ACTIVE    = 800,
    parameter int BURST_WORDS = 16,
    parameter int ADDR_W      = 21,
    parameter int FB_BASE     = 0
) (
    input  logic                           clk_psram,
    input  logic                           rst_n,
    input  logic                           line_req,
    input  logic [9:0]                     line_num,
    output logic                           busy,
    output logic                           line_done,
    output logic                           overrun,
    output logic                           cmd_valid,
    input  logic                           cmd_ready,
    output logic [ADDR_W-1:0]              cmd_addr,
    output logic [$clog2(BURST_WORDS):0]   cmd_len,
    input  logic                           rd_valid,
    input  logic [31:0]                    rd_data,
    output logic [9:0]                     wr_addr,
    output logic [23:0]                    wr_data,
    output logic                           wr_en
);

    localparam int LW = $clog2(BURST_WORDS) + 1;
    localparam int PW = 11;
    localparam logic [LW-1:0] FIRST_LEN = LW'((H_ACTIVE < BURST_WORDS) ? H_ACTIVE : BURST_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_DATA
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   line_base_q, line_base_d;
    logic [PW-1:0]       pix_cnt_q, pix_cnt_d;
    logic [LW-1:0]       beat_cnt_q, beat_cnt_d;
    logic                busy_q, busy_d;
    logic                line_done_q, line_done_d;
    logic                overrun_q, overrun_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [LW-1:0]       cmd_len_q, cmd_len_d;
    logic [9:0]          wr_addr_q, wr_addr_d;
    logic [23:0]         wr_data_q, wr_data_d;
    logic                wr_en_q, wr_en_d;

    logic [ADDR_W-1:0]   base_calc;
    logic [PW-1:0]       pix_next;
    logic [PW-1:0]       remaining;
    logic [LW-1:0]       rem_len;
    logic [7:0]          unused_rd_x;

    // The X byte of each XRGB beat is dropped.
    assign unused_rd_x = rd_data[31:24];

    // Multiplication at ADDR_W width gives the mod 2^ADDR_W wrap for free.
    assign base_calc = ADDR_W'(FB_BASE) + ADDR_W'(line_num) * ADDR_W'(H_ACTIVE);
    assign pix_next  = pix_cnt_q + PW'(1);
    assign remaining = PW'(H_ACTIVE) - pix_next;
    assign rem_len   = (remaining > PW'(BURST_WORDS)) ? LW'(BURST_WORDS) : remaining[LW-1:0];

    always_ff @(posedge clk_psram) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            line_base_q <= '0;
            pix_cnt_q   <= '0;
            beat_cnt_q  <= '0;
            busy_q      <= 1'b0;
            line_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_base_q <= line_base_d;
            pix_cnt_q   <= pix_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            busy_q      <= busy_d;
            line_done_q <= line_done_d;
            overrun_q   <= overrun_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        line_base_d = line_base_q;
        pix_cnt_d   = pix_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        busy_d      = busy_q;
        line_done_d = 1'b0;
        overrun_d   = line_req && (state_q != S_IDLE);
        cmd_valid_d = cmd_valid_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_len_d   = cmd_len_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (line_req) begin
                    line_base_d = base_calc;
                    pix_cnt_d   = '0;
                    busy_d      = 1'b1;
                    cmd_valid_d = 1'b1;
                    cmd_addr_d  = base_calc;
                    cmd_len_d   = FIRST_LEN;
                    state_d     = S_CMD;
                end
            end
            S_CMD: begin
                if (cmd_valid_q && cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    beat_cnt_d  = '0;
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                if (rd_valid) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = pix_cnt_q[9:0];
                    wr_data_d  = rd_data[23:0];
                    pix_cnt_d  = pix_next;
                    beat_cnt_d = beat_cnt_q + LW'(1);
                    if (pix_next == PW'(H_ACTIVE)) begin
                        busy_d      = 1'b0;
                        line_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else if (beat_cnt_q + LW'(1) == cmd_len_q) begin
                        // Leaving DATA here also discards any beat beyond cmd_len.
                        cmd_valid_d = 1'b1;
                        cmd_addr_d  = line_base_q + ADDR_W'(pix_next);
                        cmd_len_d   = rem_len;
                        state_d     = S_CMD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = busy_q;
    assign line_done = line_done_q;
    assign overrun   = overrun_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_len   = cmd_len_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign wr_en     = wr_en_q;

endmodule
